// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry plus Gray/binary conversion.
// Used by both the write-side (fifo_wptr_full) and read-side pointer logic.
package fifo_pkg;

  localparam int FIFO_ADDR_SIZE = 8;
  localparam int FIFO_DEPTH     = 256;

  // Conversions work on a wide container; callers zero-extend their pointer
  // in and cast the result back down to their own width.
  localparam int FIFO_PTR_MAX_W = 32;

  function automatic logic [FIFO_PTR_MAX_W-1:0] bin2gray(
    input logic [FIFO_PTR_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FIFO_PTR_MAX_W-1:0] gray2bin(
    input logic [FIFO_PTR_MAX_W-1:0] g
  );
    logic [FIFO_PTR_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < FIFO_PTR_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Width-parameterised two-flop synchroniser with asynchronous active-low reset.
// Only safe for multi-bit buses whose producer changes at most one bit per step.
module fifo_sync_2ff #(
  parameter int width_p = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] sync1_q;
  logic [width_p-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full flag and fill level for the async FIFO.
// Define FIFO_WPTR_OVERFLOW_EN to add the sticky overflow flag and its clear input.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int data_width_p = 8,
  parameter int mem_depth_p  = FIFO_DEPTH,
  parameter int addr_size_p  = FIFO_ADDR_SIZE
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic                   wr_en,
  input  logic [addr_size_p:0]   g_r_ptr,
  output logic [addr_size_p-1:0] b_w_ptr,
  output logic [addr_size_p:0]   g_w_ptr,
  output logic                   full,
`ifdef FIFO_WPTR_OVERFLOW_EN
  input  logic                   ovf_clr,
  output logic                   overflow,
`endif
  output logic [addr_size_p:0]   wr_level
);

  localparam int PW = addr_size_p + 1;

  generate
    if ((mem_depth_p != (1 << addr_size_p)) || (data_width_p < 1) || (addr_size_p < 2)) begin : g_bad_cfg
      $error("fifo_wptr_full: mem_depth_p must be 2**addr_size_p, addr_size_p >= 2");
    end
  endgenerate

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] g_w_ptr_q, g_w_ptr_d;
  logic [PW-1:0] wr_level_q, wr_level_d;
  logic          full_q, full_d;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic          wr_accept;

  fifo_sync_2ff #(
    .width_p (PW)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d_i   (g_r_ptr),
    .q_o   (rq2)
  );

  always_comb begin
    wr_accept  = wr_en & ~full_q;
    wbin_d     = wbin_q + PW'(wr_accept);
    g_w_ptr_d  = PW'(bin2gray(FIFO_PTR_MAX_W'(wbin_d)));
    rbin       = PW'(gray2bin(FIFO_PTR_MAX_W'(rq2)));
    // Full when write is exactly one lap ahead: Gray form flips the top two bits.
    full_d     = (g_w_ptr_d == {~rq2[PW-1:PW-2], rq2[PW-3:0]});
    wr_level_d = wbin_d - rbin;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q     <= '0;
      g_w_ptr_q  <= '0;
      full_q     <= 1'b0;
      wr_level_q <= '0;
    end else begin
      wbin_q     <= wbin_d;
      g_w_ptr_q  <= g_w_ptr_d;
      full_q     <= full_d;
      wr_level_q <= wr_level_d;
    end
  end

`ifdef FIFO_WPTR_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // A set in the same cycle as a clear takes priority.
  always_comb begin
    overflow_d = (wr_en & full_q) | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

  assign b_w_ptr  = wbin_q[addr_size_p-1:0];
  assign g_w_ptr  = g_w_ptr_q;
  assign full     = full_q;
  assign wr_level = wr_level_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full: fill, write-while-full, release, wrap and async reset.
// Builds with or without FIFO_WPTR_OVERFLOW_EN.
module tb_fifo_wptr_full;

  logic       wclk    = 1'b0;
  logic       wrst_n  = 1'b0;
  logic       wr_en   = 1'b0;
  logic [8:0] g_r_ptr = 9'h000;
  logic [7:0] b_w_ptr;
  logic [8:0] g_w_ptr;
  logic       full;
  logic [8:0] wr_level;
`ifdef FIFO_WPTR_OVERFLOW_EN
  logic       ovf_clr = 1'b0;
  logic       overflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: write count, synchroniser stages, derived flags.
  logic [8:0] wbin_m, rbin_m, s1_m, s2_m, lvl_m;
  logic       full_m, ovf_m;
  int         acc_m;

  fifo_wptr_full #(
    .data_width_p (8),
    .mem_depth_p  (256),
    .addr_size_p  (8)
  ) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .wr_en    (wr_en),
    .g_r_ptr  (g_r_ptr),
    .b_w_ptr  (b_w_ptr),
    .g_w_ptr  (g_w_ptr),
    .full     (full),
`ifdef FIFO_WPTR_OVERFLOW_EN
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
`endif
    .wr_level (wr_level)
  );

  always #5 wclk = ~wclk;

  function automatic logic [8:0] b2g(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [8:0] g2b(input logic [8:0] g);
    logic [8:0] b;
    b[8] = g[8];
    for (int i = 7; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic model_reset();
    wbin_m = '0; rbin_m = '0; s1_m = '0; s2_m = '0; lvl_m = '0;
    full_m = 1'b0; ovf_m = 1'b0; acc_m = 0;
  endtask

  // One clock edge; the reference is advanced with the inputs seen at that edge.
  task automatic step();
    logic       we, ce;
    logic [8:0] gr;
    we = wr_en;
    gr = g_r_ptr;
    ce = 1'b0;
`ifdef FIFO_WPTR_OVERFLOW_EN
    ce = ovf_clr;
`endif
    @(posedge wclk);
    #1;
    ovf_m = (we && full_m) || (ovf_m && !ce);
    if (we && !full_m) begin
      wbin_m = wbin_m + 9'd1;
      acc_m++;
    end
    lvl_m  = wbin_m - g2b(s2_m);
    full_m = (lvl_m == 9'd256);
    s2_m   = s1_m;
    s1_m   = gr;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    wr_en  = 1'b1;
    repeat (3) @(posedge wclk);
    #1;
    n_cmp++; if (b_w_ptr !== 8'h00) begin n_bad++; $display("FAIL reset_b_w_ptr got %h want 00", b_w_ptr); end
    n_cmp++; if (g_w_ptr !== 9'h000) begin n_bad++; $display("FAIL reset_g_w_ptr got %h want 000", g_w_ptr); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (wr_level !== 9'd0) begin n_bad++; $display("FAIL reset_wr_level got %0d want 0", wr_level); end
`ifdef FIFO_WPTR_OVERFLOW_EN
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
`endif
    wr_en  = 1'b0;
    wrst_n = 1'b1;
    model_reset();
    $display("reset: outputs cleared, released");
  endtask

  task automatic test_fill();
    g_r_ptr = 9'h000;
    wr_en   = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      n_cmp++; if (full !== full_m) begin n_bad++; $display("FAIL fill_full[%0d] got %b want %b", i, full, full_m); end
      n_cmp++; if (wr_level !== lvl_m) begin n_bad++; $display("FAIL fill_level[%0d] got %0d want %0d", i, wr_level, lvl_m); end
      n_cmp++; if (g_w_ptr !== b2g(wbin_m)) begin n_bad++; $display("FAIL fill_gptr[%0d] got %h want %h", i, g_w_ptr, b2g(wbin_m)); end
      if (i == 255) begin
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL fill_full_255 got %b want 0", full); end
      end
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full_256 got %b want 1", full); end
    n_cmp++; if (b_w_ptr !== 8'h00) begin n_bad++; $display("FAIL fill_b_w_ptr got %h want 00", b_w_ptr); end
    n_cmp++; if (g_w_ptr !== 9'h180) begin n_bad++; $display("FAIL fill_g_w_ptr got %h want 180", g_w_ptr); end
    n_cmp++; if (wr_level !== 9'd256) begin n_bad++; $display("FAIL fill_wr_level got %0d want 256", wr_level); end
    $display("fill: 256 writes, full=%b g_w_ptr=%h wr_level=%0d", full, g_w_ptr, wr_level);
  endtask

  task automatic test_write_while_full();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (b_w_ptr !== 8'h00) begin n_bad++; $display("FAIL wwf_b_w_ptr[%0d] got %h want 00", i, b_w_ptr); end
      n_cmp++; if (g_w_ptr !== 9'h180) begin n_bad++; $display("FAIL wwf_g_w_ptr[%0d] got %h want 180", i, g_w_ptr); end
      n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL wwf_full[%0d] got %b want 1", i, full); end
`ifdef FIFO_WPTR_OVERFLOW_EN
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL wwf_overflow[%0d] got %b want 1", i, overflow); end
`endif
    end
    wr_en = 1'b0;
    $display("write_while_full: 5 dropped writes, b_w_ptr=%h g_w_ptr=%h", b_w_ptr, g_w_ptr);
  endtask

  task automatic test_read_release();
    rbin_m  = 9'd1;
    g_r_ptr = 9'h001;
    step();
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL rel_full_e1 got %b want 1", full); end
    step();
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL rel_full_e2 got %b want 1", full); end
    n_cmp++; if (wr_level !== 9'd256) begin n_bad++; $display("FAIL rel_level_e2 got %0d want 256", wr_level); end
    step();
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rel_full_e3 got %b want 0", full); end
    n_cmp++; if (wr_level !== 9'd255) begin n_bad++; $display("FAIL rel_level_e3 got %0d want 255", wr_level); end
    $display("read_release: full=%b wr_level=%0d after 3 edges", full, wr_level);
  endtask

  task automatic test_interleave();
    int         base;
    logic [8:0] prev;
    bit         wrapped;
    base    = acc_m;
    wrapped = 1'b0;
    for (int cyc = 0; cyc < 4000 && (acc_m - base) < 600; cyc++) begin
      wr_en = ((cyc % 3) != 2);
      if ((cyc % 2) == 0 && rbin_m != wbin_m) rbin_m = rbin_m + 9'd1;
      g_r_ptr = b2g(rbin_m);
      prev = g_w_ptr;
      step();
      n_cmp++; if (wr_level !== lvl_m) begin n_bad++; $display("FAIL il_level[%0d] got %0d want %0d", cyc, wr_level, lvl_m); end
      n_cmp++; if (full !== full_m) begin n_bad++; $display("FAIL il_full[%0d] got %b want %b", cyc, full, full_m); end
      n_cmp++; if (g_w_ptr !== b2g(wbin_m)) begin n_bad++; $display("FAIL il_gptr[%0d] got %h want %h", cyc, g_w_ptr, b2g(wbin_m)); end
      n_cmp++; if ($countones(g_w_ptr ^ prev) > 1) begin n_bad++; $display("FAIL il_gray_step[%0d] got %h after %h want one-bit change", cyc, g_w_ptr, prev); end
      if (prev == 9'h100 && g_w_ptr == 9'h000) wrapped = 1'b1;
    end
    wr_en = 1'b0;
    n_cmp++; if ((acc_m - base) !== 600) begin n_bad++; $display("FAIL il_write_count got %0d want 600", acc_m - base); end
    n_cmp++; if (wrapped !== 1'b1) begin n_bad++; $display("FAIL il_wrap got %b want 1", wrapped); end
    $display("interleave: %0d writes, wrap_seen=%b wr_level=%0d", acc_m - base, wrapped, wr_level);
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1;
    repeat (3) step();
    @(posedge wclk);
    #3;
    wrst_n = 1'b0;
    #1;
    n_cmp++; if (b_w_ptr !== 8'h00) begin n_bad++; $display("FAIL arst_b_w_ptr got %h want 00", b_w_ptr); end
    n_cmp++; if (g_w_ptr !== 9'h000) begin n_bad++; $display("FAIL arst_g_w_ptr got %h want 000", g_w_ptr); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL arst_full got %b want 0", full); end
    n_cmp++; if (wr_level !== 9'd0) begin n_bad++; $display("FAIL arst_wr_level got %0d want 0", wr_level); end
`ifdef FIFO_WPTR_OVERFLOW_EN
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL arst_overflow got %b want 0", overflow); end
`endif
    repeat (2) @(posedge wclk);
    #1;
    n_cmp++; if (b_w_ptr !== 8'h00) begin n_bad++; $display("FAIL arst_hold_b_w_ptr got %h want 00", b_w_ptr); end
    wr_en   = 1'b0;
    g_r_ptr = 9'h000;
    model_reset();
    wrst_n  = 1'b1;
    n_cmp++; if (b_w_ptr !== 8'h00) begin n_bad++; $display("FAIL arst_first_addr got %h want 00", b_w_ptr); end
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    n_cmp++; if (b_w_ptr !== 8'h01) begin n_bad++; $display("FAIL arst_after_write got %h want 01", b_w_ptr); end
    n_cmp++; if (g_w_ptr !== 9'h001) begin n_bad++; $display("FAIL arst_after_gptr got %h want 001", g_w_ptr); end
    n_cmp++; if (wr_level !== 9'd1) begin n_bad++; $display("FAIL arst_after_level got %0d want 1", wr_level); end
    $display("async_reset: cleared mid-burst, first write went to address 0");
  endtask

`ifdef FIFO_WPTR_OVERFLOW_EN
  task automatic test_overflow();
    wr_en = 1'b1;
    while (!full_m && acc_m < 300) step();
    step();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", overflow); end
    wr_en   = 1'b0;
    ovf_clr = 1'b1;
    step();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", overflow); end
    n_cmp++; if (overflow !== ovf_m) begin n_bad++; $display("FAIL ovf_model got %b want %b", overflow, ovf_m); end
    wr_en = 1'b1;
    step();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    $display("overflow: set, clear and set-wins checked");
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_write_while_full();
    test_read_release();
    test_interleave();
    test_async_reset();
`ifdef FIFO_WPTR_OVERFLOW_EN
    test_overflow();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. It runs entirely on `wclk` and drives the binary write address (`b_w_ptr`) and `full` into the dual-clock FIFO memory. It publishes a Gray-coded write pointer for the read-domain logic. It also synchronises the read side's Gray pointer into `wclk` to compute `full` and the write-side fill level.

## Interface
Parameters:
- `data_width_p`, 8: carried for consistency with the memory; unused in logic.
- `mem_depth_p`, 256: FIFO depth; must equal 2**`addr_size_p`.
- `addr_size_p`, 8: memory address width; internal pointers are `addr_size_p`+1 bits (extra wrap bit).

Ports:
- `wclk`, input, 1: write clock.
- `wrst_n`, input, 1: reset, asynchronous, active-low.
- `wr_en`, input, 1: write request; the same signal drives the memory.
- `g_r_ptr`, input, `addr_size_p`+1: Gray read pointer from the read domain, asynchronous to `wclk`.
- `b_w_ptr`, output, `addr_size_p`: binary write address to the memory.
- `g_w_ptr`, output, `addr_size_p`+1: registered Gray write pointer to the read domain.
- `full`, output, 1: registered FIFO-full flag.
- `wr_level`, output, `addr_size_p`+1: registered fill level, 0..`mem_depth_p`, as seen from the write side.
- `ovf_clr`, input, 1 (macro only): clears `overflow`.
- `overflow`, output, 1 (macro only): sticky write-while-full flag.

## Operation
- Internal binary pointer `wbin` is `addr_size_p`+1 bits. `b_w_ptr` = `wbin[addr_size_p-1:0]`. `g_w_ptr` = `(wbin>>1)^wbin`, held in a register.
- Accepted write means `wr_en & ~full` at a `wclk` rising edge.
  - On an accepted write, `wbin_next` = `wbin`+1, wrapping modulo 2**(`addr_size_p`+1).
  - Otherwise `wbin_next` = `wbin`.
- The memory writes `mem[b_w_ptr]` at the same edge, using the pre-increment value.
- `g_r_ptr` passes through two flops (`rq1`, `rq2`). Only `rq2` is used.
- `full_next` is asserted when `gray(wbin_next)` equals `rq2` with its two MSBs inverted and the remaining bits equal.
- `wr_level_next` = `wbin_next` − `gray2bin(rq2)`, computed modulo 2**(`addr_size_p`+1). It is never greater than `mem_depth_p`.
- `wr_en` while `full` is ignored. The pointer holds and no wrap or corruption occurs.
- `full` is pessimistic: it may stay high up to 3 edges after the read side frees space. It never reports not-full when the FIFO is actually full.
- Reset at any time, including mid-burst, asynchronously clears `wbin`, `g_w_ptr`, `rq1`, `rq2`, `full`, `wr_level` and `overflow`. No write is accepted while `wrst_n`=0.

## Timing
- Reset values: `b_w_ptr`=0, `g_w_ptr`=0, `full`=0, `wr_level`=0, `overflow`=0.
- Write-to-`b_w_ptr`/`g_w_ptr` latency: 1 edge. The pointers update at the accepting edge.
- Write-to-`full`: same edge. `full` rises at the edge that accepts the `mem_depth_p`-th unread word.
- Read-pointer change to `full`/`wr_level` update: `g_r_ptr` is captured into `rq1` at edge N and moves to `rq2` at N+1. `full` and `wr_level` reflect it after edge N+2.
- A write and a read-pointer change in the same cycle are both reflected. The write counts immediately; the read counts after synchroniser latency.
- `g_r_ptr` is guaranteed Gray-coded by its producer, so at most one bit changes per read-clock step.

## Configuration
- `FIFO_WPTR_OVERFLOW_EN` defined:
  - Adds the `ovf_clr` input and the `overflow` output.
  - `overflow` is set at any edge with `wr_en & full`, and stays set until an edge with `ovf_clr`=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined: both ports are absent. Writes while full are silently dropped.

## Structure
- Shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterised by width.
  - Default constants `FIFO_ADDR_SIZE`=8 and `FIFO_DEPTH`=256.
  - The same package is used by the future read-side `fifo_rptr_empty`.
- One sub-module: `fifo_sync_2ff`, a width-parameterised two-flop synchroniser with async active-low reset. It is reused by the read side.

## Test plan
- Reset, then 256 writes with `g_r_ptr`=0:
  - `full` rises at the 256th accepting edge.
  - `b_w_ptr`=0, `g_w_ptr`=9'h180, `wr_level`=256.
- While full, hold `wr_en`=1 for 5 cycles: `b_w_ptr` and `g_w_ptr` stay unchanged. With the macro, `overflow`=1 from the first such edge.
- From full, set `g_r_ptr`=9'h001: `full` stays high for 2 edges, then falls after the 3rd edge with `wr_level`=255.
- Interleave writes and Gray read-pointer advances for 600 writes:
  - `g_w_ptr` wraps past 9'h100 back to 9'h000.
  - Only one bit changes per update.
  - `wr_level` always equals accepted writes minus synchronised reads.
- Assert `wrst_n`=0 mid-burst, asynchronously between edges: all outputs go to 0 immediately. After release, the first write goes to address 0.
- Macro build: `ovf_clr` pulse clears `overflow`. With `ovf_clr` and `wr_en & full` in the same cycle, `overflow` remains 1.
